// File: rtl/phys_reg_read_stage_pkg.sv
// Shared defaults and operand type for the register-read stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phys_reg_read_stage_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_WR_DEF   = 2;
  localparam int ZERO_REG_DEF = 31;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  // One source operand as it travels down the pipe: value, final flag, source tag.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  rdy;
    logic [ADDR_W_DEF-1:0] tag;
  } operand_t;

endpackage

// File: rtl/phys_reg_read_stage_if.sv
// Request, writeback and result bundle between issue, writeback and the read stage.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
interface phys_reg_read_stage_if
  import phys_reg_read_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_WR = NUM_WR_DEF
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        in_rs1;
  logic [ADDR_W-1:0]        in_rs2;
  logic                     in_b_sel;
  logic [DATA_W-1:0]        in_imm;
  logic                     in_alloc_en;
  logic [ADDR_W-1:0]        in_rd;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_a;
  logic [DATA_W-1:0]        out_b;
  logic                     out_a_rdy;
  logic                     out_b_rdy;
  logic [ADDR_W-1:0]        out_rs2;

  // Issue/writeback/consumer side.
  modport master (
    output in_valid, in_rs1, in_rs2, in_b_sel, in_imm, in_alloc_en, in_rd,
    output wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_a_rdy, out_b_rdy, out_rs2
  );

  // Read stage side.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_b_sel, in_imm, in_alloc_en, in_rd,
    input  wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_a_rdy, out_b_rdy, out_rs2
  );

endinterface

// File: rtl/phys_reg_read_stage_reg_bank_bypass.sv
// Register array plus scoreboard ready bits, NUM_WR write ports, 2 bypassed read ports.
// Latency: reads combinational (same-cycle writes forwarded), writes land at posedge.
// Backpressure: none; writes and allocs are always taken.
module phys_reg_read_stage_reg_bank_bypass
  import phys_reg_read_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WR-1:0]             wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]      wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]      wr_data,
  input  logic                          alloc_en,
  input  logic [ADDR_W-1:0]             alloc_addr,
  input  logic [1:0][ADDR_W-1:0]        rd_addr,
  output logic [1:0][DATA_W-1:0]        rd_data,
  output logic [1:0]                    rd_rdy
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] ready;
  logic [ADDR_W-1:0]   wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];

  // Unpack the flat writeback buses into per-port views.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wa[i] = wr_addr[i*ADDR_W +: ADDR_W];
      wd[i] = wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Array and scoreboard update: later ports override earlier ones, alloc applied last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      ready <= '1;
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wa[i] != ZERO_A)) begin
          regs[wa[i]]  <= wd[i];
          ready[wa[i]] <= 1'b1;
        end
      end
      if (alloc_en && (alloc_addr != ZERO_A)) ready[alloc_addr] <= 1'b0;
    end
  end

  // Read ports: array value, overridden by the highest matching writeback, then by the zero register.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs[rd_addr[p]];
      rd_rdy[p]  = ready[rd_addr[p]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wr_en[i] && (wa[i] == rd_addr[p])) begin
          rd_data[p] = wd[i];
          rd_rdy[p]  = 1'b1;
        end
      end
      if (rd_addr[p] == ZERO_A) begin
        rd_data[p] = '0;
        rd_rdy[p]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phys_reg_read_stage.sv
// Register-read stage: reads rs1/rs2 (or imm for B), scoreboards rd, one-deep output slot.
// Latency: 1 cycle from accept to out_valid; a stalled slot snoops writebacks.
// Backpressure: in_ready = !out_valid || out_ready; the slot holds while out_ready is low.
module phys_reg_read_stage
  import phys_reg_read_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  phys_reg_read_stage_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              rdy;
    logic [ADDR_W-1:0] tag;
  } op_t;

  logic                   valid_q;
  logic                   b_sel_q;
  op_t                    a_q, b_q;
  op_t                    a_in, b_in;
  op_t                    a_snoop, b_snoop;
  logic                   accept;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_rdy;
  logic [ADDR_W-1:0]      wa [NUM_WR];
  logic [DATA_W-1:0]      wd [NUM_WR];

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  phys_reg_read_stage_reg_bank_bypass #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .wr_data    (bus.wr_data),
    .alloc_en   (accept && bus.in_alloc_en),
    .alloc_addr (bus.in_rd),
    .rd_addr    ({bus.in_rs2, bus.in_rs1}),
    .rd_data    (rd_data),
    .rd_rdy     (rd_rdy)
  );

  // Per-port writeback views for the stalled-slot snoop.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wa[i] = bus.wr_addr[i*ADDR_W +: ADDR_W];
      wd[i] = bus.wr_data[i*DATA_W +: DATA_W];
    end
  end

  // Operands to load on accept; an immediate B is final and carries tag 0.
  always_comb begin
    a_in = '{data: rd_data[0], rdy: rd_rdy[0], tag: bus.in_rs1};
    if (bus.in_b_sel) b_in = '{data: bus.in_imm, rdy: 1'b1, tag: '0};
    else              b_in = '{data: rd_data[1], rdy: rd_rdy[1], tag: bus.in_rs2};
  end

  // Held operands still waiting pick up a matching writeback; highest port wins.
  always_comb begin
    a_snoop = a_q;
    b_snoop = b_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (!a_q.rdy && bus.wr_en[i] && (wa[i] == a_q.tag)) begin
        a_snoop.data = wd[i];
        a_snoop.rdy  = 1'b1;
      end
      if (!b_sel_q && !b_q.rdy && bus.wr_en[i] && (wa[i] == b_q.tag)) begin
        b_snoop.data = wd[i];
        b_snoop.rdy  = 1'b1;
      end
    end
  end

  // Output slot: load on accept, drain on consume, otherwise hold with snoop.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      b_sel_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      b_sel_q <= bus.in_b_sel;
      a_q     <= a_in;
      b_q     <= b_in;
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      a_q <= a_snoop;
      b_q <= b_snoop;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_a     = a_q.data;
  assign bus.out_b     = b_q.data;
  assign bus.out_a_rdy = a_q.rdy;
  assign bus.out_b_rdy = b_q.rdy;
  assign bus.out_rs2   = b_q.tag;

endmodule

// File: tb/tb_phys_reg_read_stage.sv
// Directed bench for phys_reg_read_stage: vector table plus stall/reset sequences.
module tb_phys_reg_read_stage;
  import phys_reg_read_stage_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phys_reg_read_stage_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW)) bus ();

  phys_reg_read_stage #(
    .DATA_W(DW), .NUM_REGS(32), .NUM_WR(NW), .ZERO_REG(31)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic          iv;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          bsel;
    logic [63:0]   imm;
    logic          al;
    logic [4:0]    rd;
    logic [1:0]    wen;
    logic [4:0]    wa0;
    logic [63:0]   wd0;
    logic [4:0]    wa1;
    logic [63:0]   wd1;
    logic          ordy;
    logic          ev;
    logic          ck;
    logic [63:0]   ea;
    logic [63:0]   eb;
    logic          ear;
    logic          ebr;
    logic [4:0]    ers2;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_rs1      = '0;
    bus.in_rs2      = '0;
    bus.in_b_sel    = 1'b0;
    bus.in_imm      = '0;
    bus.in_alloc_en = 1'b0;
    bus.in_rd       = '0;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.out_ready   = 1'b1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid    = v.iv;
    bus.in_rs1      = v.rs1;
    bus.in_rs2      = v.rs2;
    bus.in_b_sel    = v.bsel;
    bus.in_imm      = v.imm;
    bus.in_alloc_en = v.al;
    bus.in_rd       = v.rd;
    bus.wr_en       = v.wen;
    bus.wr_addr     = {v.wa1, v.wa0};
    bus.wr_data     = {v.wd1, v.wd0};
    bus.out_ready   = v.ordy;
  endtask

  int sent;
  int recv;
  logic fire_in;
  logic fire_out;

  initial begin
    //           iv    rs1    rs2    bs    imm          al    rd     wen    wa0    wd0            wa1    wd1        ordy  ev    ck    ea             eb             ear   ebr   ers2
    vecs[0]  = '{1'b1, 5'd5,  5'd6,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h0,         64'h0,         1'b1, 1'b1, 5'd6};
    vecs[1]  = '{1'b1, 5'd3,  5'd3,  1'b0, 64'h0,       1'b0, 5'd0,  2'b01, 5'd3,  64'hDEAD,      5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'hDEAD,      64'hDEAD,      1'b1, 1'b1, 5'd3};
    vecs[2]  = '{1'b1, 5'd4,  5'd3,  1'b0, 64'h0,       1'b0, 5'd0,  2'b11, 5'd4,  64'h1,         5'd4,  64'h2,     1'b1, 1'b1, 1'b1, 64'h2,         64'hDEAD,      1'b1, 1'b1, 5'd3};
    vecs[3]  = '{1'b1, 5'd4,  5'd5,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h2,         64'h0,         1'b1, 1'b1, 5'd5};
    vecs[4]  = '{1'b1, 5'd3,  5'd9,  1'b1, 64'h1000,    1'b0, 5'd0,  2'b01, 5'd31, 64'h5,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'hDEAD,      64'h1000,      1'b1, 1'b1, 5'd0};
    vecs[5]  = '{1'b1, 5'd31, 5'd31, 1'b0, 64'h0,       1'b0, 5'd0,  2'b10, 5'd0,  64'h0,         5'd31, 64'h7,     1'b1, 1'b1, 1'b1, 64'h0,         64'h0,         1'b1, 1'b1, 5'd31};
    vecs[6]  = '{1'b1, 5'd1,  5'd2,  1'b0, 64'h0,       1'b1, 5'd7,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h0,         64'h0,         1'b1, 1'b1, 5'd2};
    vecs[7]  = '{1'b1, 5'd7,  5'd7,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h0,         64'h0,         1'b0, 1'b0, 5'd7};
    vecs[8]  = '{1'b0, 5'd0,  5'd0,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b0, 1'b1, 1'b1, 64'h0,         64'h0,         1'b0, 1'b0, 5'd7};
    vecs[9]  = '{1'b0, 5'd0,  5'd0,  1'b0, 64'h0,       1'b0, 5'd0,  2'b10, 5'd0,  64'h0,         5'd7,  64'h42,    1'b0, 1'b1, 1'b1, 64'h42,        64'h42,        1'b1, 1'b1, 5'd7};
    vecs[10] = '{1'b0, 5'd0,  5'd0,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b0, 1'b0, 64'h0,         64'h0,         1'b0, 1'b0, 5'd0};
    vecs[11] = '{1'b1, 5'd8,  5'd8,  1'b0, 64'h0,       1'b1, 5'd8,  2'b01, 5'd8,  64'h55,        5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h55,        64'h55,        1'b1, 1'b1, 5'd8};
    vecs[12] = '{1'b1, 5'd8,  5'd8,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h55,        64'h55,        1'b0, 1'b0, 5'd8};
    vecs[13] = '{1'b1, 5'd8,  5'd5,  1'b0, 64'h0,       1'b0, 5'd0,  2'b01, 5'd8,  64'h66,        5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h66,        64'h0,         1'b1, 1'b1, 5'd5};
    vecs[14] = '{1'b0, 5'd0,  5'd0,  1'b0, 64'h0,       1'b1, 5'd9,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b0, 1'b0, 64'h0,         64'h0,         1'b0, 1'b0, 5'd0};
    vecs[15] = '{1'b1, 5'd9,  5'd9,  1'b0, 64'h0,       1'b0, 5'd0,  2'b00, 5'd0,  64'h0,         5'd0,  64'h0,     1'b1, 1'b1, 1'b1, 64'h0,         64'h0,         1'b1, 1'b1, 5'd9};

    // Reset: slot empty while reset is held, all outputs zero afterwards.
    reset = 1'b1;
    idle_inputs();
    tick();
    chk("rst_valid_during", 64'(bus.out_valid), 64'd0);
    tick();
    reset = 1'b0;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_a", bus.out_a, 64'd0);
    chk("rst_b", bus.out_b, 64'd0);
    chk("rst_a_rdy", 64'(bus.out_a_rdy), 64'd0);
    chk("rst_rs2", 64'(bus.out_rs2), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
      if (vecs[i].ck) begin
        chk($sformatf("v%0d_a", i), bus.out_a, vecs[i].ea);
        chk($sformatf("v%0d_b", i), bus.out_b, vecs[i].eb);
        chk($sformatf("v%0d_a_rdy", i), 64'(bus.out_a_rdy), 64'(vecs[i].ear));
        chk($sformatf("v%0d_b_rdy", i), 64'(bus.out_b_rdy), 64'(vecs[i].ebr));
        chk($sformatf("v%0d_rs2", i), 64'(bus.out_rs2), 64'(vecs[i].ers2));
      end
    end

    // Preload r10..r17 with 0x100..0x107.
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      bus.wr_en   = 2'b01;
      bus.wr_addr = {5'd0, 5'(10 + k)};
      bus.wr_data = {64'd0, 64'(256 + k)};
      tick();
    end
    idle_inputs();

    // 8 requests against a consumer whose out_ready toggles every cycle.
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
      bus.out_ready = cyc[0];
      bus.in_valid  = (sent < 8);
      bus.in_rs1    = 5'(10 + sent);
      bus.in_rs2    = 5'(10 + sent);
      #3;
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        chk($sformatf("seq_a%0d", recv), bus.out_a, 64'(256 + recv));
        recv++;
      end
      tick();
      if (fire_in) sent++;
    end
    chk("seq_count", 64'(recv), 64'd8);
    idle_inputs();
    tick();

    // Reset while a stalled slot holds an allocating request.
    bus.in_valid    = 1'b1;
    bus.in_rs1      = 5'd12;
    bus.in_rs2      = 5'd12;
    bus.in_alloc_en = 1'b1;
    bus.in_rd       = 5'd12;
    bus.out_ready   = 1'b0;
    tick();
    chk("stall_load_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_load_a", bus.out_a, 64'h102);
    bus.in_valid    = 1'b0;
    bus.in_alloc_en = 1'b0;
    tick();
    chk("stall_hold_valid", 64'(bus.out_valid), 64'd1);
    chk("stall_hold_a", bus.out_a, 64'h102);
    reset           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_alloc_en = 1'b1;
    bus.in_rd       = 5'd13;
    bus.wr_en       = 2'b01;
    bus.wr_addr     = {5'd0, 5'd12};
    bus.wr_data     = {64'd0, 64'h77};
    tick();
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_a", bus.out_a, 64'd0);
    chk("midrst_a_rdy", 64'(bus.out_a_rdy), 64'd0);
    reset           = 1'b0;
    bus.wr_en       = '0;
    bus.in_alloc_en = 1'b0;
    bus.in_rs1      = 5'd12;
    bus.in_rs2      = 5'd13;
    bus.out_ready   = 1'b1;
    tick();
    chk("postrst_valid", 64'(bus.out_valid), 64'd1);
    chk("postrst_a", bus.out_a, 64'd0);
    chk("postrst_a_rdy", 64'(bus.out_a_rdy), 64'd1);
    chk("postrst_b_rdy", 64'(bus.out_b_rdy), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
